// File: rtl/param_fir_transposed.sv
// Transposed-form FIR with a run-time coefficient table and a latched active tap count.
// Define FIR_SAT_EN to saturate the output; otherwise the output wraps to OUT_W bits.
module param_fir_transposed #(
    parameter int DATA_W    = 3,
    parameter int COEF_W    = 16,
    parameter int NUM_TAPS  = 40,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 0,
    localparam int AW       = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
    input  logic                     iClk_12M,
    input  logic                     iRsn,
    input  logic                     iEnSample_300k,
    input  logic                     iCoeffiUpdateFlag,
    input  logic                     iCsnRam,
    input  logic                     iWrnRam,
    input  logic [AW-1:0]            iAddrRam,
    input  logic signed [COEF_W-1:0] iWrDtRam,
    input  logic [6:0]               iNumOfCoeff,
    input  logic signed [DATA_W-1:0] iFirIn,
    output logic signed [OUT_W-1:0]  oFirOut,
    output logic                     oFirValid,
    output logic [1:0]               oState
);

    localparam int ACC_W  = DATA_W + COEF_W + $clog2(NUM_TAPS);
    localparam int WIDE_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
    localparam logic [6:0] MAX_N = 7'(NUM_TAPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } stateT;

    stateT                    stateReg;
    logic [6:0]               numTapsReg;
    logic signed [COEF_W-1:0] coefReg [NUM_TAPS];
    logic signed [ACC_W-1:0]  zReg    [NUM_TAPS];
    logic signed [ACC_W-1:0]  zNext   [NUM_TAPS];
    logic signed [ACC_W-1:0]  yShift;
    logic                     runStrobe;
    logic                     enterLoad;
    logic                     coefWr;

    // A strobe on the same edge as RUN->LOAD is dropped, hence the flag term.
    assign runStrobe = (stateReg == RUN) && !iCoeffiUpdateFlag && iEnSample_300k;
    assign enterLoad = (stateReg != LOAD) && iCoeffiUpdateFlag;
    assign coefWr    = (stateReg == LOAD) && !iCsnRam && !iWrnRam;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TAPS; gi++) begin : gTap
            localparam logic [6:0] TAP_IDX = 7'(gi);
            logic signed [ACC_W-1:0] prod;

            assign prod = ACC_W'(iFirIn) * ACC_W'(coefReg[gi]);

            // Taps at or beyond the active count are forced to zero so a later
            // increase of N never exposes stale partial sums.
            if (gi < NUM_TAPS - 1) begin : gMid
                assign zNext[gi] = (TAP_IDX + 7'd1 < numTapsReg) ? prod + zReg[gi + 1]
                                 : (TAP_IDX < numTapsReg)        ? prod
                                 : '0;
            end else begin : gLast
                assign zNext[gi] = (TAP_IDX < numTapsReg) ? prod : '0;
            end
        end
    endgenerate

    // The new head of the chain is exactly x*c[0] + z[1]old, i.e. the filter output.
    assign yShift = zNext[0] >>> OUT_SHIFT;

`ifdef FIR_SAT_EN
    localparam logic signed [WIDE_W-1:0] ONE_W   = 1;
    localparam logic signed [WIDE_W-1:0] SAT_MAX = (ONE_W <<< (OUT_W - 1)) - ONE_W;
    localparam logic signed [WIDE_W-1:0] SAT_MIN = -(ONE_W <<< (OUT_W - 1));

    function automatic logic signed [OUT_W-1:0] narrowOut(input logic signed [ACC_W-1:0] v);
        logic signed [WIDE_W-1:0] wide;
        wide = WIDE_W'(v);
        if (wide > SAT_MAX)
            return SAT_MAX[OUT_W-1:0];
        else if (wide < SAT_MIN)
            return SAT_MIN[OUT_W-1:0];
        else
            return wide[OUT_W-1:0];
    endfunction
`else
    function automatic logic signed [OUT_W-1:0] narrowOut(input logic signed [ACC_W-1:0] v);
        logic signed [WIDE_W-1:0] wide;
        wide = WIDE_W'(v);
        return wide[OUT_W-1:0];
    endfunction
`endif

    always_ff @(posedge iClk_12M) begin
        if (!iRsn) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                zReg[i]    <= '0;
                coefReg[i] <= '0;
            end
        end else begin
            if (enterLoad) begin
                for (int i = 0; i < NUM_TAPS; i++) zReg[i] <= '0;
            end else if (runStrobe) begin
                for (int i = 0; i < NUM_TAPS; i++) zReg[i] <= zNext[i];
            end
            // Addresses at or above NUM_TAPS match no entry and are dropped.
            for (int i = 0; i < NUM_TAPS; i++) begin
                if (coefWr && (iAddrRam == AW'(i)))
                    coefReg[i] <= iWrDtRam;
            end
        end
    end

    always_ff @(posedge iClk_12M) begin
        if (!iRsn) begin
            stateReg   <= IDLE;
            numTapsReg <= '0;
            oFirOut    <= '0;
            oFirValid  <= 1'b0;
        end else begin
            oFirValid <= runStrobe;
            if (runStrobe)
                oFirOut <= narrowOut(yShift);
            case (stateReg)
                IDLE: if (iCoeffiUpdateFlag) stateReg <= LOAD;
                LOAD: if (!iCoeffiUpdateFlag) begin
                    stateReg   <= RUN;
                    numTapsReg <= (iNumOfCoeff > MAX_N) ? MAX_N : iNumOfCoeff;
                end
                RUN:  if (iCoeffiUpdateFlag) stateReg <= LOAD;
                default: stateReg <= IDLE;
            endcase
        end
    end

    assign oState = stateReg;

endmodule

// File: tb/tb_param_fir_transposed.sv
// Directed bench for param_fir_transposed: stimulus queues expected outputs,
// a negedge monitor pops and compares on every oFirValid pulse.
module tb_param_fir_transposed;

    localparam int DATA_W   = 3;
    localparam int COEF_W   = 16;
    localparam int NUM_TAPS = 40;
    localparam int OUT_W    = 16;
    localparam int AW       = $clog2(NUM_TAPS);

`ifdef FIR_SAT_EN
    localparam int EXP_NEG = -32768;
    localparam int EXP_POS = 32767;
`else
    localparam int EXP_NEG = 4;
    localparam int EXP_POS = 32765;
`endif

    logic                     clk = 1'b0;
    logic                     iRsn;
    logic                     iEnSample_300k;
    logic                     iCoeffiUpdateFlag;
    logic                     iCsnRam;
    logic                     iWrnRam;
    logic [AW-1:0]            iAddrRam;
    logic signed [COEF_W-1:0] iWrDtRam;
    logic [6:0]               iNumOfCoeff;
    logic signed [DATA_W-1:0] iFirIn;
    logic signed [OUT_W-1:0]  oFirOut;
    logic                     oFirValid;
    logic [1:0]               oState;

    int checks   = 0;
    int failures = 0;
    int expQ[$];
    int expVal;
    int txn = 0;

    param_fir_transposed #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .NUM_TAPS(NUM_TAPS), .OUT_W(OUT_W), .OUT_SHIFT(0)
    ) dut (
        .iClk_12M(clk),
        .iRsn(iRsn),
        .iEnSample_300k(iEnSample_300k),
        .iCoeffiUpdateFlag(iCoeffiUpdateFlag),
        .iCsnRam(iCsnRam),
        .iWrnRam(iWrnRam),
        .iAddrRam(iAddrRam),
        .iWrDtRam(iWrDtRam),
        .iNumOfCoeff(iNumOfCoeff),
        .iFirIn(iFirIn),
        .oFirOut(oFirOut),
        .oFirValid(oFirValid),
        .oState(oState)
    );

    always #5 clk = ~clk;

    // Monitor: every valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (oFirValid === 1'b1) begin
            checks++;
            txn++;
            if (expQ.size() == 0) begin
                failures++;
                $display("FAIL out_unexpected txn=%0d got=%0d required=no_valid", txn, oFirOut);
            end else begin
                expVal = expQ.pop_front();
                if (int'(oFirOut) != expVal) begin
                    failures++;
                    $display("FAIL out_value txn=%0d got=%0d required=%0d", txn, oFirOut, expVal);
                end else begin
                    $display("txn %0d out=%0d ok", txn, oFirOut);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, act, req);
        end else begin
            $display("check %s=%0d ok", name, act);
        end
    endtask

    task automatic wr(input int addr, input int data);
        iCsnRam  = 1'b0;
        iWrnRam  = 1'b0;
        iAddrRam = AW'(addr);
        iWrDtRam = COEF_W'(data);
        tick();
        iCsnRam  = 1'b1;
        iWrnRam  = 1'b1;
    endtask

    task automatic strobe(input int x, input int expOut);
        iFirIn         = DATA_W'(x);
        iEnSample_300k = 1'b1;
        expQ.push_back(expOut);
        tick();
        iEnSample_300k = 1'b0;
        tick();
    endtask

    task automatic enterRun(input int n);
        iNumOfCoeff       = 7'(n);
        iCoeffiUpdateFlag = 1'b0;
        tick();
    endtask

    initial begin
        iRsn = 1'b0; iEnSample_300k = 1'b0; iCoeffiUpdateFlag = 1'b0;
        iCsnRam = 1'b1; iWrnRam = 1'b1; iAddrRam = '0; iWrDtRam = '0;
        iNumOfCoeff = '0; iFirIn = '0;
        tick(); tick();
        chk("rst_state", int'(oState), 0);
        chk("rst_out", int'(oFirOut), 0);
        chk("rst_valid", int'(oFirValid), 0);
        iRsn = 1'b1;

        // Strobe in IDLE must be ignored (monitor flags any valid).
        iFirIn = 3'sd1; iEnSample_300k = 1'b1; tick(); iEnSample_300k = 1'b0; tick();
        chk("idle_state", int'(oState), 0);

        iCoeffiUpdateFlag = 1'b1; tick();
        chk("load_state", int'(oState), 1);
        wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 4);
        wr(NUM_TAPS, 99);
        enterRun(4);
        chk("run_state", int'(oState), 2);

        // Impulse then step response with c = 1,2,3,4.
        strobe(1, 1); strobe(0, 2); strobe(0, 3); strobe(0, 4); strobe(0, 0);
        iNumOfCoeff = 7'd1;
        strobe(1, 1); strobe(1, 3); strobe(1, 6); strobe(1, 10); strobe(1, 10);

        // Write in RUN is ignored: c0 stays 1, chain is 10,9,7,4.
        wr(0, 5);
        strobe(1, 10);
        strobe(0, 9); strobe(0, 7); strobe(0, 4); strobe(0, 0);

        // Mid-impulse reload flushes the chain; coincident strobe is dropped.
        strobe(1, 1); strobe(0, 2);
        iCoeffiUpdateFlag = 1'b1; iFirIn = 3'sd1; iEnSample_300k = 1'b1;
        tick();
        chk("reload_state", int'(oState), 1);
        chk("load_hold_out", int'(oFirOut), 2);
        tick();
        iEnSample_300k = 1'b0;
        enterRun(4);
        chk("rerun_state", int'(oState), 2);
        strobe(0, 0); strobe(-2, -2); strobe(0, -4); strobe(3, -3);

        // N = 0 produces a valid zero.
        iCoeffiUpdateFlag = 1'b1; tick();
        enterRun(0);
        strobe(3, 0);

        // N = 1 with full-scale coefficient exercises narrowing.
        iCoeffiUpdateFlag = 1'b1; tick();
        wr(0, 32767);
        enterRun(1);
        strobe(-4, EXP_NEG); strobe(3, EXP_POS);

        // Reset beats a coincident strobe and flag.
        iRsn = 1'b0; iCoeffiUpdateFlag = 1'b1; iFirIn = 3'sd1; iEnSample_300k = 1'b1;
        tick();
        chk("rst_run_state", int'(oState), 0);
        chk("rst_run_out", int'(oFirOut), 0);
        chk("rst_run_valid", int'(oFirValid), 0);
        iRsn = 1'b1; iCoeffiUpdateFlag = 1'b0; iEnSample_300k = 1'b0;
        tick();
        chk("post_rst_state", int'(oState), 0);

        tick(); tick();
        chk("queue_empty", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
